burst_initiator: RTL

BURST_INITIATOR -- requirements
Module: burst_initiator

---
 rtl/burst_initiator.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/burst_initiator.sv
// Burst initiator: accepts one burst command, drives a seeded beat sequence to a receiver,
// and reports first-beat acknowledge, completion, wait timeouts and early-done protocol errors.
module burst_initiator #(
  parameter int ACK_DELAY = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_length,
  input  logic [1:0]  cmd_mode,
  input  logic [31:0] cmd_seed,
  output logic        start_burst,
  output logic [3:0]  burst_length,
  output logic [1:0]  burst_mode,
  output logic [31:0] data_in,
  output logic        data_valid,
  output logic        first_ack,
  input  logic        first_beat,
  input  logic        burst_done,
  output logic        busy,
  output logic        tx_done,
  output logic [4:0]  beats_sent,
  output logic        timeout_err,
  output logic        proto_err
);

  localparam int              TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]      DLY_LAST = 3'(ACK_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE, START, FIRST, WAIT_FB, ACK, STREAM, WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    dly_cnt_q, dly_cnt_d;
  logic          fb_seen_q, fb_seen_d;
  logic [31:0]   seed_q, seed_d;
  logic [4:0]    n_beats;

  logic        ready_d, start_d, dv_d, ack_d, busy_d, txd_d, terr_d, perr_d;
  logic [3:0]  len_d;
  logic [1:0]  mode_d;
  logic [31:0] data_d;
  logic [4:0]  beats_d;

  assign n_beats = (burst_length <= 4'd1) ? 5'd1 : {1'b0, burst_length} + 5'd1;

  // Every output is computed here for the upcoming cycle and then registered,
  // so each pulse lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    fb_seen_d  = fb_seen_q;
    seed_d     = seed_q;
    len_d      = burst_length;
    mode_d     = burst_mode;
    data_d     = data_in;
    beats_d    = beats_sent;
    terr_d     = timeout_err;
    perr_d     = proto_err;
    start_d    = 1'b0;
    dv_d       = 1'b0;
    ack_d      = 1'b0;
    txd_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d   = cmd_length;
          mode_d  = cmd_mode;
          seed_d  = cmd_seed;
          terr_d  = 1'b0;
          perr_d  = 1'b0;
          beats_d = 5'd0;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        dv_d    = 1'b1;
        data_d  = seed_q;
        beats_d = 5'd1;
        state_d = FIRST;
      end
      FIRST: begin
        wait_cnt_d = '0;
        dly_cnt_d  = 3'd0;
        fb_seen_d  = 1'b0;
        state_d    = WAIT_FB;
      end
      WAIT_FB: begin
        // Once first_beat is seen the timeout stops and only the ack delay runs.
        if (fb_seen_q) begin
          if (dly_cnt_q == DLY_LAST) begin
            ack_d   = 1'b1;
            state_d = ACK;
          end else begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end
        end else if (first_beat) begin
          if (DLY_LAST == 3'd0) begin
            ack_d   = 1'b1;
            state_d = ACK;
          end else begin
            fb_seen_d = 1'b1;
            dly_cnt_d = 3'd1;
          end
        end else if (wait_cnt_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (n_beats > 5'd1) begin
          dv_d    = 1'b1;
          data_d  = seed_q + 32'd1;
          beats_d = beats_sent + 5'd1;
          state_d = STREAM;
        end else begin
          wait_cnt_d = '0;
          state_d    = WAIT_DONE;
        end
      end
      STREAM: begin
        if (beats_sent == n_beats) begin
          wait_cnt_d = '0;
          state_d    = WAIT_DONE;
        end else begin
          dv_d    = 1'b1;
          data_d  = data_in + 32'd1;
          beats_d = beats_sent + 5'd1;
        end
      end
      WAIT_DONE: begin
        if (burst_done) begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (burst_done && (state_q inside {START, FIRST, WAIT_FB, ACK, STREAM}))
      perr_d = 1'b1;

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      dly_cnt_q    <= 3'd0;
      fb_seen_q    <= 1'b0;
      seed_q       <= 32'd0;
      cmd_ready    <= 1'b0;
      start_burst  <= 1'b0;
      burst_length <= 4'd0;
      burst_mode   <= 2'd0;
      data_in      <= 32'd0;
      data_valid   <= 1'b0;
      first_ack    <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      beats_sent   <= 5'd0;
      timeout_err  <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      fb_seen_q    <= fb_seen_d;
      seed_q       <= seed_d;
      cmd_ready    <= ready_d;
      start_burst  <= start_d;
      burst_length <= len_d;
      burst_mode   <= mode_d;
      data_in      <= data_d;
      data_valid   <= dv_d;
      first_ack    <= ack_d;
      busy         <= busy_d;
      tx_done      <= txd_d;
      beats_sent   <= beats_d;
      timeout_err  <= terr_d;
      proto_err    <= perr_d;
    end
  end

endmodule
